// File: rtl/fixed_div_sequencer_if.sv
// Operand/result handshake bundle for fixed_div_sequencer.
// Master drives operands and out_ready; slave returns result and status.
interface fixed_div_sequencer_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] numerator;
    logic [N-1:0] denominator;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic         div_by_zero;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, numerator, denominator, out_ready,
        input  in_ready, out_valid, quotient,
        input  div_by_zero, overflow, busy
    );

    modport slave (
        input  in_valid, numerator, denominator, out_ready,
        output in_ready, out_valid, quotient,
        output div_by_zero, overflow, busy
    );
endinterface

// File: rtl/fixed_div_sequencer.sv
// Sequential sign-magnitude fixed-point divider: Newton-Raphson
// reciprocal on one shared multiplier, then a multiply by the numerator.
module fixed_div_sequencer #(
    parameter int N    = 32,
    parameter int Q    = 16,
    parameter int ITER = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fixed_div_sequencer_if.slave bus
);
    localparam int M  = N - 1;
    localparam int IW = 4;
    localparam logic [M-1:0] TWO = M'(2) << Q;

    typedef enum logic [2:0] {
        IDLE, INIT, DX, XE, NQ, DONE
    } state_t;

    state_t         state;
    logic [M-1:0]   x;
    logic [M-1:0]   t;
    logic [M-1:0]   d;
    logic [M-1:0]   n_mag;
    logic           sign;
    logic           dz;
    logic           ov;
    logic [IW-1:0]  iter;

    logic [M-1:0]   mul_a;
    logic [M-1:0]   mul_b;
    logic [2*M-1:0] prod;
    logic [M-1:0]   mul_res;
    logic           mul_ov;
    logic [M-1:0]   e;
    logic [M-1:0]   x0;
    logic           sh_ov;
    int             p;
    int             sh;
    logic [M-1:0]   q_mag;
    logic           q_sign;
    logic           q_ov;
    logic           unused_lsb;

    // Shared multiplier operands chosen by the current step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            DX:      begin mul_a = d;     mul_b = x; end
            XE:      begin mul_a = x;     mul_b = e; end
            NQ:      begin mul_a = n_mag; mul_b = x; end
            default: begin end
        endcase
    end

    assign prod       = (2*M)'(mul_a) * (2*M)'(mul_b);
    assign mul_res    = prod[M+Q-1:Q];
    assign mul_ov     = |prod[2*M-1:M+Q];
    assign unused_lsb = ^prod[Q-1:0];
    assign e          = (t >= TWO) ? '0 : TWO - t;

    // Seed: power of two just below 1/d so the iteration rises to it.
    always_comb begin
        p = 0;
        for (int i = 0; i < M; i++) begin
            if (d[i]) p = i;
        end
        sh    = 2*Q - 1 - p;
        sh_ov = (sh > N - 2);
        x0    = '0;
        if (d != '0 && !sh_ov && sh >= 0) x0 = M'(1) << sh;
    end

    // Final result with saturation; zero magnitudes carry a clear sign.
    always_comb begin
        q_ov   = (ov && n_mag != '0) || mul_ov;
        q_mag  = (dz || q_ov) ? '1 : mul_res;
        q_sign = sign && n_mag != '0 && q_mag != '0;
    end

    // Sequencer with registered handshake, result and flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            x               <= '0;
            t               <= '0;
            d               <= '0;
            n_mag           <= '0;
            sign            <= 1'b0;
            dz              <= 1'b0;
            ov              <= 1'b0;
            iter            <= '0;
            bus.in_ready    <= 1'b1;
            bus.busy        <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        n_mag           <= bus.numerator[M-1:0];
                        d               <= bus.denominator[M-1:0];
                        sign            <= bus.numerator[N-1]
                                         ^ bus.denominator[N-1];
                        dz              <= 1'b0;
                        ov              <= 1'b0;
                        bus.quotient    <= '0;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        bus.in_ready    <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= INIT;
                    end
                end
                INIT: begin
                    dz    <= (d == '0);
                    ov    <= sh_ov && (d != '0);
                    x     <= x0;
                    iter  <= '0;
                    state <= DX;
                end
                DX: begin
                    t     <= mul_res;
                    state <= XE;
                end
                XE: begin
                    x <= mul_res;
                    if (iter == IW'(ITER - 1)) begin
                        state <= NQ;
                    end else begin
                        iter  <= iter + 1'b1;
                        state <= DX;
                    end
                end
                NQ: begin
                    bus.quotient    <= {q_sign, q_mag};
                    bus.div_by_zero <= dz;
                    bus.overflow    <= q_ov;
                    bus.out_valid   <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_div_sequencer.sv
// Scoreboard bench for fixed_div_sequencer: directed corner cases,
// backpressure, mid-operation reset and model-checked random operands.
module tb_fixed_div_sequencer;
    localparam int N    = 32;
    localparam int Q    = 16;
    localparam int ITER = 5;

    typedef struct packed {
        logic [31:0] q;
        logic        dz;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   chk_x = 1'b0;
    logic [30:0] xexp [5];

    fixed_div_sequencer_if #(.N(N)) bus ();

    fixed_div_sequencer #(.N(N), .Q(Q), .ITER(ITER)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] q,
                                input logic dz, input logic ov);
        exp_t r;
        r.q  = q;
        r.dz = dz;
        r.ov = ov;
        return r;
    endfunction

    // Independent reference written with 64-bit integer arithmetic.
    function automatic exp_t model(input logic [31:0] num,
                                   input logic [31:0] den);
        longint unsigned nm, dm, x, t, e, pr, two, mask, mag;
        int p, sh;
        bit dz, ov, fov, s;
        mask = 64'h7FFF_FFFF;
        two  = 64'h2 << Q;
        nm   = {33'd0, num[30:0]};
        dm   = {33'd0, den[30:0]};
        p    = 0;
        for (int i = 0; i < 31; i++) if (dm[i]) p = i;
        dz = (dm == 0);
        sh = 2*Q - 1 - p;
        ov = !dz && (sh > N - 2);
        x  = (dz || ov) ? 64'd0 : (64'd1 << sh);
        for (int k = 0; k < ITER; k++) begin
            t = ((dm * x) >> Q) & mask;
            e = (t >= two) ? 64'd0 : two - t;
            x = ((x * e) >> Q) & mask;
        end
        pr  = nm * x;
        fov = (pr >> 47) != 0;
        ov  = (ov && nm != 0) || fov;
        mag = (dz || ov) ? mask : ((pr >> Q) & mask);
        s   = (num[31] ^ den[31]) && nm != 0 && mag != 0;
        return mk({s, mag[30:0]}, dz, ov);
    endfunction

    // Caller sits just after a rising edge; returns likewise.
    task automatic op(input logic [31:0] num,
                      input logic [31:0] den,
                      input exp_t ex);
        int n;
        int lat;
        bus.in_valid    = 1'b1;
        bus.numerator   = num;
        bus.denominator = den;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 50), 0);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (chk_x && lat >= 4 && lat <= 12 && lat % 2 == 0)
                check("x_iter", dut.x, xexp[lat/2-2]);
        end while (!bus.out_valid && lat < 100);
        check("latency", lat, 13);
        check("busy_done", bus.busy, 1);
        @(posedge clk);
        #1;
    endtask

    // Result monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin : mon
        exp_t ex;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                ex = sb.pop_front();
                check("quotient", bus.quotient, ex.q);
                check("div_by_zero", bus.div_by_zero, ex.dz);
                check("overflow", bus.overflow, ex.ov);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rn, rd;
        xexp[0] = 31'h6000;
        xexp[1] = 31'h7800;
        xexp[2] = 31'h7F80;
        xexp[3] = 31'h7FFF;
        xexp[4] = 31'h7FFF;
        bus.in_valid    = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        bus.out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        chk_x = 1'b1;
        op(32'h0006_0000, 32'h0002_0000, mk(32'h0002_FFFA, 0, 0));
        chk_x = 1'b0;
        op(32'h8006_0000, 32'h0002_0000, mk(32'h8002_FFFA, 0, 0));
        op(32'h0000_0000, 32'h8003_0000, mk(32'h0000_0000, 0, 0));
        op(32'h0005_0000, 32'h0000_0000, mk(32'h7FFF_FFFF, 1, 0));
        op(32'h0001_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 0, 1));
        op(32'h7FFF_0000, 32'h0000_0100, mk(32'h7FFF_FFFF, 0, 1));
        op(32'h0000_0000, 32'h8000_0000, mk(32'h7FFF_FFFF, 1, 0));

        bus.out_ready = 1'b0;
        op(32'h0006_0000, 32'h0002_0000, mk(32'h0002_FFFA, 0, 0));
        for (int i = 0; i < 20; i++) begin
            bus.in_valid    = 1'b1;
            bus.numerator   = $urandom;
            bus.denominator = $urandom;
            @(negedge clk);
            check("hold_quotient", bus.quotient, 32'h0002_FFFA);
            check("hold_flags", {bus.div_by_zero, bus.overflow}, 0);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", bus.in_ready, 1);
        check("release_out_valid", bus.out_valid, 0);
        check("release_busy", bus.busy, 0);
        op(32'h0009_0000, 32'h0003_0000,
           model(32'h0009_0000, 32'h0003_0000));

        bus.in_valid    = 1'b1;
        bus.numerator   = 32'h0006_0000;
        bus.denominator = 32'h0002_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_quotient", bus.quotient, 0);
        check("mid_rst_flags", {bus.div_by_zero, bus.overflow}, 0);
        check("mid_rst_busy", bus.busy, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        op(32'h8001_8000, 32'h0000_4000,
           model(32'h8001_8000, 32'h0000_4000));

        for (int i = 0; i < 8; i++) begin
            rn = {1'($urandom), 31'($urandom_range(1, 32'h00FF_FFFF))};
            rd = {1'($urandom), 31'($urandom_range(32'h100, 32'h007F_FFFF))};
            op(rn, rd, model(rn, rd));
        end

        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
